// File: rtl/ee357_mcpu_pkg.sv
// Shared definitions for the EE357 multicycle CPU memory responder and control unit.
//   - mem_state_e   : responder FSM states (idle / wait-state countdown / response)
//   - WORD_W        : data word width
//   - MEM_ERR_DATA  : read data returned for an errored access
//   - OP_*          : instruction opcodes decoded by the control unit
//   - mem_access_err: access-error predicate used when error checking is built in
package ee357_mcpu_pkg;

  localparam int unsigned WORD_W = 32;
  localparam logic [31:0] MEM_ERR_DATA = 32'hDEADBEEF;

  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StResp
  } mem_state_e;

  // Misaligned, out-of-range word index, or an ambiguous read+write request.
  function automatic logic mem_access_err(logic [31:0] addr, logic mr, logic mw,
                                          int unsigned depth_words);
    return (addr[1:0] != 2'b00) || ({2'b00, addr[31:2]} >= depth_words) || (mr && mw);
  endfunction

endpackage

// File: rtl/ee357_mcpu_mem_if.sv
// Memory request/response bundle between the CPU (master) and the memory responder (slave).
//   mr, mw : read / write request levels, held until ready
//   addr   : byte address; wdata: write data
//   rdata  : read data; ready: one-cycle completion pulse; err: access error with ready
interface ee357_mcpu_mem_if;
  import ee357_mcpu_pkg::*;

  logic              mr;
  logic              mw;
  logic [WORD_W-1:0] addr;
  logic [WORD_W-1:0] wdata;
  logic [WORD_W-1:0] rdata;
  logic              ready;
  logic              err;

  modport master (
    output mr, mw, addr, wdata,
    input  rdata, ready, err
  );

  modport slave (
    input  mr, mw, addr, wdata,
    output rdata, ready, err
  );

endinterface

// File: rtl/ee357_mem_array.sv
// Single-port synchronous word RAM. Write and read happen on the same edge; the read
// returns the contents before the write. Contents are not reset.
//   clk  : clock
//   we   : write enable
//   idx  : word index
//   din  : write data
//   dout : registered read data of mem[idx]
module ee357_mem_array #(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] idx,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[idx] <= din;
    end
    dout <= mem[idx];
  end

endmodule

// File: rtl/ee357_mcpu_mem.sv
// Unified instruction/data memory responder for the EE357 multicycle CPU.
// A request (mr|mw) seen in idle is latched, held for WAIT_STATES cycles, then answered
// with a one-cycle ready pulse. Write wins when mr and mw are both high.
//   clk, rst : clock, synchronous active-high reset
//   bus      : ee357_mcpu_mem_if slave (mr, mw, addr, wdata -> rdata, ready, err)
// Optional feature macro: EE357_MEM_ERRCHK_EN. When defined, misaligned, out-of-range or
// read+write requests return err with ready, errored writes are dropped and errored reads
// return MEM_ERR_DATA. When undefined, err is tied 0, addr[1:0] is ignored and the word
// index wraps modulo DEPTH_WORDS.
module ee357_mcpu_mem
  import ee357_mcpu_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned WAIT_STATES = 2
) (
  input logic             clk,
  input logic             rst,
  ee357_mcpu_mem_if.slave bus
);

  localparam int unsigned IdxW = $clog2(DEPTH_WORDS);

  mem_state_e        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [IdxW-1:0]   idx_q, cur_idx;
  logic [WORD_W-1:0] wdata_q, cur_wdata;
  logic [WORD_W-1:0] rdata_q, rdata_mux, ram_dout;
  logic              wr_q, cur_wr, cur_err;
  logic              accept, to_resp, ram_we, resp_rd;

  assign accept = (state_q == StIdle) && (bus.mr || bus.mw);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    to_resp = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.mr || bus.mw) begin
          if (WAIT_STATES == 0) begin
            state_d = StResp;
            to_resp = 1'b1;
          end else begin
            state_d = StWait;
            cnt_d   = 4'(WAIT_STATES - 1);
          end
        end
      end
      StWait: begin
        if (cnt_q == 4'd0) begin
          state_d = StResp;
          to_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StResp: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // With zero wait states the RAM access happens on the acceptance edge itself, so the
  // live request drives the RAM in idle and the latched copy drives it afterwards.
  assign cur_idx   = (state_q == StIdle) ? bus.addr[IdxW+1:2] : idx_q;
  assign cur_wdata = (state_q == StIdle) ? bus.wdata : wdata_q;
  assign cur_wr    = (state_q == StIdle) ? bus.mw : wr_q;

`ifdef EE357_MEM_ERRCHK_EN
  logic err_q;
  logic acc_err;

  assign acc_err = mem_access_err(bus.addr, bus.mr, bus.mw, DEPTH_WORDS);
  assign cur_err = (state_q == StIdle) ? acc_err : err_q;
  assign bus.err = (state_q == StResp) && err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (accept) begin
      err_q <= acc_err;
    end
  end
`else
  logic unused_addr;

  assign cur_err     = 1'b0;
  assign bus.err     = 1'b0;
  assign unused_addr = ^{bus.addr[WORD_W-1:IdxW+2], bus.addr[1:0]};
`endif

  // Commit only on the edge that enters the response state; a reset on that edge drops it.
  assign ram_we = to_resp && cur_wr && !cur_err && !rst;

  ee357_mem_array #(
    .DEPTH (DEPTH_WORDS),
    .WIDTH (WORD_W)
  ) u_mem_array (
    .clk  (clk),
    .we   (ram_we),
    .idx  (cur_idx),
    .din  (cur_wdata),
    .dout (ram_dout)
  );

  // rdata shows fresh read data during the response and otherwise holds the last read.
  assign resp_rd   = (state_q == StResp) && !wr_q;
  assign rdata_mux = resp_rd ? (cur_err ? MEM_ERR_DATA : ram_dout) : rdata_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      idx_q   <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_mux;
      if (accept) begin
        idx_q   <= bus.addr[IdxW+1:2];
        wdata_q <= bus.wdata;
        wr_q    <= bus.mw;
      end
    end
  end

  assign bus.rdata = rdata_mux;
  assign bus.ready = (state_q == StResp);

endmodule

// File: tb/tb_ee357_mcpu_mem.sv
// Bench for ee357_mcpu_mem: one instance with two wait states (index 0) and one with zero
// wait states (index 1). Directed table, held-request and reset sequences, then random
// accesses against a word-addressed reference memory.
module tb_ee357_mcpu_mem;

`ifdef EE357_MEM_ERRCHK_EN
  localparam bit ErrChk = 1'b1;
`else
  localparam bit ErrChk = 1'b0;
`endif
  localparam int Depth = 256;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ee357_mcpu_mem_if bus2 ();
  ee357_mcpu_mem_if bus0 ();

  ee357_mcpu_mem #(.DEPTH_WORDS(Depth), .WAIT_STATES(2)) u_dut2 (
    .clk (clk),
    .rst (rst),
    .bus (bus2.slave)
  );

  ee357_mcpu_mem #(.DEPTH_WORDS(Depth), .WAIT_STATES(0)) u_dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0.slave)
  );

  int n_cmp = 0;
  int n_err = 0;
  int ws [2] = '{2, 0};
  logic [31:0] last_rd [2];

  typedef struct {
    int          d;
    logic        r;
    logic        w;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input int d, input logic r, input logic w, input logic [31:0] a,
                       input logic [31:0] wd);
    if (d == 0) begin
      bus2.mr = r; bus2.mw = w; bus2.addr = a; bus2.wdata = wd;
    end else begin
      bus0.mr = r; bus0.mw = w; bus0.addr = a; bus0.wdata = wd;
    end
  endtask

  function automatic logic rdy(input int d);
    return (d == 0) ? bus2.ready : bus0.ready;
  endfunction

  function automatic logic [31:0] rdat(input int d);
    return (d == 0) ? bus2.rdata : bus0.rdata;
  endfunction

  function automatic logic erf(input int d);
    return (d == 0) ? bus2.err : bus0.err;
  endfunction

  // Starts just after a rising edge; returns the number of falling edges until ready.
  task automatic do_access(input string name, input int d, input logic r, input logic w,
                           input logic [31:0] a, input logic [31:0] wd,
                           output logic [31:0] rd, output logic er);
    int lat = 0;
    rd = '0;
    er = 1'b0;
    drive(d, r, w, a, wd);
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (rdy(d)) begin
        lat = i;
        rd  = rdat(d);
        er  = erf(d);
        break;
      end
    end
    drive(d, 1'b0, 1'b0, 32'h0, 32'h0);
    check({name, " latency"}, 32'(lat), 32'(ws[d] + 2));
    @(negedge clk);
    check({name, " ready one cycle"}, 32'(rdy(d)), 32'h0);
    @(posedge clk);
    #1;
  endtask

  vec_t vecs [13];
  logic [31:0] mdl [2][int];

  initial begin
    logic [31:0] rd;
    logic        er;
    int          pulses, first, second;
    logic [31:0] prd [2];

    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("reset ready[%0d]", d), 32'(rdy(d)), 32'h0);
      check($sformatf("reset err[%0d]", d), 32'(erf(d)), 32'h0);
      check($sformatf("reset rdata[%0d]", d), rdat(d), 32'h0);
      last_rd[d] = 32'h0;
    end
    @(posedge clk);
    #1;

    vecs[0]  = '{0, 1'b0, 1'b1, 32'h10,  32'hCAFEF00D, 32'h0, 1'b0};
    vecs[1]  = '{0, 1'b1, 1'b0, 32'h10,  32'h0, 32'hCAFEF00D, 1'b0};
    vecs[2]  = '{0, 1'b0, 1'b1, 32'h0,   32'h00000001, 32'h0, 1'b0};
    vecs[3]  = '{0, 1'b0, 1'b1, 32'h400, 32'hA5A5A5A5, 32'h0, ErrChk};
    vecs[4]  = '{0, 1'b1, 1'b0, 32'h0,   32'h0, ErrChk ? 32'h1 : 32'hA5A5A5A5, 1'b0};
    vecs[5]  = '{0, 1'b1, 1'b0, 32'h2,   32'h0, ErrChk ? 32'hDEADBEEF : 32'hA5A5A5A5, ErrChk};
    vecs[6]  = '{0, 1'b0, 1'b1, 32'h20,  32'h00000077, 32'h0, 1'b0};
    vecs[7]  = '{0, 1'b1, 1'b1, 32'h20,  32'h000055AA, 32'h0, ErrChk};
    vecs[8]  = '{0, 1'b1, 1'b0, 32'h20,  32'h0, ErrChk ? 32'h77 : 32'h55AA, 1'b0};
    vecs[9]  = '{1, 1'b0, 1'b1, 32'h0,   32'h13579BDF, 32'h0, 1'b0};
    vecs[10] = '{1, 1'b1, 1'b0, 32'h0,   32'h0, 32'h13579BDF, 1'b0};
    vecs[11] = '{1, 1'b0, 1'b1, 32'h8,   32'h2468ACE0, 32'h0, 1'b0};
    vecs[12] = '{1, 1'b1, 1'b0, 32'h8,   32'h0, 32'h2468ACE0, 1'b0};

    for (int i = 0; i < 13; i++) begin
      do_access($sformatf("vec%0d", i), vecs[i].d, vecs[i].r, vecs[i].w, vecs[i].a,
                vecs[i].wd, rd, er);
      check($sformatf("vec%0d err", i), 32'(er), 32'(vecs[i].exp_err));
      // A write leaves rdata at the previous read value.
      if (vecs[i].w) begin
        check($sformatf("vec%0d rdata held", i), rd, last_rd[vecs[i].d]);
      end else begin
        check($sformatf("vec%0d rdata", i), rd, vecs[i].exp_rd);
        last_rd[vecs[i].d] = vecs[i].exp_rd;
      end
    end

    // Held mr: the idle cycle after a response accepts the same request again.
    pulses = 0;
    first  = 0;
    second = 0;
    drive(0, 1'b1, 1'b0, 32'h10, 32'h0);
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (bus2.ready) begin
        pulses++;
        prd[pulses-1] = bus2.rdata;
        if (pulses == 1) first = i;
        else second = i;
        if (pulses == 2) break;
      end
    end
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    check("held pulses", 32'(pulses), 32'd2);
    check("held first latency", 32'(first), 32'd4);
    check("held spacing", 32'(second - first), 32'd4);
    check("held rdata0", prd[0], 32'hCAFEF00D);
    check("held rdata1", prd[1], 32'hCAFEF00D);
    last_rd[0] = 32'hCAFEF00D;
    @(negedge clk);
    check("held ready drops", 32'(bus2.ready), 32'h0);
    @(posedge clk);
    #1;

    // Reset during the wait states drops a pending write.
    do_access("pre-reset write", 0, 1'b0, 1'b1, 32'hC, 32'h11111111, rd, er);
    drive(0, 1'b0, 1'b1, 32'hC, 32'h00001234);
    @(posedge clk);
    #1;
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("rst ready %0d", i), 32'(bus2.ready), 32'h0);
    end
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    rst = 1'b0;
    check("rst rdata cleared", bus2.rdata, 32'h0);
    @(negedge clk);
    check("post-rst ready", 32'(bus2.ready), 32'h0);
    @(posedge clk);
    #1;
    do_access("post-rst read", 0, 1'b1, 1'b0, 32'hC, 32'h0, rd, er);
    check("post-rst word3", rd, 32'h11111111);
    last_rd[0] = rd;
    last_rd[1] = 32'h0;

    // Random accesses on words 64..79 against a word-indexed reference memory.
    for (int n = 0; n < 80; n++) begin
      int          d;
      int          op;
      logic        r, w, e_err;
      logic [31:0] a, wd, e_rd;
      logic [31:0] widx;
      logic        known;
      d  = int'($urandom_range(0, 1));
      op = int'($urandom_range(0, 5));
      r  = (op <= 2) || (op == 5);
      w  = (op >= 3);
      widx = 32'(64 + $urandom_range(0, 15));
      a  = widx * 4;
      if ($urandom_range(0, 3) == 0) a = a + ($urandom_range(0, 3) + 4 * Depth * $urandom_range(0, 7));
      wd = $urandom;
      e_err = ErrChk && ((a % 4 != 0) || ((a / 4) >= Depth) || (r && w));
      widx  = (a / 4) % Depth;
      known = 1'b1;
      e_rd  = last_rd[d];
      if (!w) begin
        if (e_err) e_rd = 32'hDEADBEEF;
        else if (mdl[d].exists(int'(widx))) e_rd = mdl[d][int'(widx)];
        else known = 1'b0;
      end
      do_access($sformatf("rnd%0d", n), d, r, w, a, wd, rd, er);
      check($sformatf("rnd%0d err", n), 32'(er), 32'(e_err));
      if (known) check($sformatf("rnd%0d rdata", n), rd, e_rd);
      if (!w) last_rd[d] = rd;
      if (w && !e_err) mdl[d][int'(widx)] = wd;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
